// File: rtl/t64_pkg.sv
// Shared types and helpers for the t64 register/memory transfer logic.
package t64_pkg;

    localparam int T64_DATA_W = 64;

    typedef enum logic [1:0] {
        W8  = 2'd0,
        W16 = 2'd1,
        W32 = 2'd2,
        W64 = 2'd3
    } width_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        REQ  = 3'd2,
        WB   = 3'd3,
        FIN  = 3'd4
    } state_e;

    function automatic logic [T64_DATA_W-1:0] width_mask(input width_e w);
        case (w)
            W8:      width_mask = 64'h0000_0000_0000_00FF;
            W16:     width_mask = 64'h0000_0000_0000_FFFF;
            W32:     width_mask = 64'h0000_0000_FFFF_FFFF;
            default: width_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [3:0] width_bytes(input width_e w);
        case (w)
            W8:      width_bytes = 4'd1;
            W16:     width_bytes = 4'd2;
            W32:     width_bytes = 4'd4;
            default: width_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational lowest-set-bit encoder over a 16-bit vector, with a valid flag.
module prio_enc16 (
    input  logic [15:0] bits,
    output logic [3:0]  idx,
    output logic        valid
);

    // Descending scan so the last hit, the lowest index, wins.
    always_comb begin
        idx   = 4'd0;
        valid = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (bits[i]) begin
                idx   = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_xfer_seq.sv
// Store/load-multiple sequencer: walks a register mask and moves each register to/from memory.
// Optional abort input/aborted output enabled with `define REG_XFER_SEQ_ABORT_EN.
//   state | meaning
//   IDLE  | waiting for start
//   SCAN  | pick lowest remaining register, capture store data
//   REQ   | memory request held until mem_ack
//   WB    | regfile write of loaded data
//   FIN   | one-cycle done pulse
module reg_xfer_seq
    import t64_pkg::*;
#(
    parameter int NREGS  = 16,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     load,
    input  logic [NREGS-1:0]         mask,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [1:0]               width,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NREGS)-1:0] rf_rdsel,
    input  logic [DATA_W-1:0]        rf_rddata,
    output logic [$clog2(NREGS)-1:0] rf_wrsel,
    output logic [DATA_W-1:0]        rf_din,
    output logic                     rf_wr,
    output logic [1:0]               rf_width,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
`ifdef REG_XFER_SEQ_ABORT_EN
    input  logic                     abort,
    output logic                     aborted,
`endif
    input  logic [DATA_W-1:0]        mem_rdata
);

    state_e                     state, state_nxt;
    logic                       load_r;
    width_e                     width_r;
    logic [NREGS-1:0]           mask_rem;
    logic [ADDR_W-1:0]          addr_r;
    logic [$clog2(NREGS)-1:0]   cur_r;
    logic [DATA_W-1:0]          data_r;
    logic [DATA_W-1:0]          wmask;
    logic [3:0]                 enc_idx;
    logic                       enc_valid;
    logic                       abort_in;
    logic                       abort_pend;
    logic                       abort_any;

`ifdef REG_XFER_SEQ_ABORT_EN
    logic aborted_r;
    assign abort_in = abort;
    assign aborted  = aborted_r;
`else
    assign abort_in = 1'b0;
`endif

    assign abort_any = abort_in | abort_pend;
    assign wmask     = DATA_W'(width_mask(width_r));

    prio_enc16 u_enc (
        .bits  (mask_rem),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rf_rdsel  = '0;
        rf_wr     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SCAN;
            end
            SCAN: begin
                busy     = 1'b1;
                rf_rdsel = enc_idx;
                if (!enc_valid || abort_any) state_nxt = FIN;
                else                         state_nxt = REQ;
            end
            REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = !load_r;
                if (mem_ack) begin
                    // A pending abort on a load still lets the write-back finish.
                    if (load_r)         state_nxt = WB;
                    else if (abort_any) state_nxt = FIN;
                    else                state_nxt = SCAN;
                end
            end
            WB: begin
                busy      = 1'b1;
                rf_wr     = 1'b1;
                state_nxt = abort_any ? FIN : SCAN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_r     <= 1'b0;
            width_r    <= W8;
            mask_rem   <= '0;
            addr_r     <= '0;
            cur_r      <= '0;
            data_r     <= '0;
            abort_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        load_r     <= load;
                        width_r    <= width_e'(width);
                        mask_rem   <= mask;
                        addr_r     <= base_addr;
                        abort_pend <= 1'b0;
                    end
                end
                SCAN: begin
                    if (enc_valid && !abort_any) begin
                        cur_r <= enc_idx;
                        if (!load_r) data_r <= rf_rddata & wmask;
                    end
                end
                REQ: begin
                    if (abort_in) abort_pend <= 1'b1;
                    if (mem_ack) begin
                        mask_rem[cur_r] <= 1'b0;
                        addr_r          <= addr_r + ADDR_W'(width_bytes(width_r));
                        if (load_r) data_r <= mem_rdata & wmask;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef REG_XFER_SEQ_ABORT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            aborted_r <= 1'b0;
        end else if (state == IDLE && start) begin
            aborted_r <= 1'b0;
        end else if (busy && state_nxt == FIN && abort_any) begin
            aborted_r <= 1'b1;
        end
    end
`endif

    assign rf_wrsel  = cur_r;
    assign rf_din    = data_r;
    assign rf_width  = width_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = data_r;

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Scoreboard bench for reg_xfer_seq: stimulus pushes expected transfers, a monitor pops and compares.
module tb_reg_xfer_seq;

    logic        clk = 1'b0;
    logic        reset, start, load;
    logic [15:0] mask;
    logic [63:0] base_addr;
    logic [1:0]  width;
    logic        busy, done, rf_wr, mem_req, mem_we, mem_ack;
    logic [3:0]  rf_rdsel, rf_wrsel;
    logic [63:0] rf_rddata, rf_din, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  rf_width;
`ifdef REG_XFER_SEQ_ABORT_EN
    logic        abort, aborted;
`endif

    always #5 clk = ~clk;

    logic [63:0] regs [16];
    logic [63:0] mem [logic [63:0]];
    assign rf_rddata = regs[rf_rdsel];

    reg_xfer_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load      (load),
        .mask      (mask),
        .base_addr (base_addr),
        .width     (width),
        .busy      (busy),
        .done      (done),
        .rf_rdsel  (rf_rdsel),
        .rf_rddata (rf_rddata),
        .rf_wrsel  (rf_wrsel),
        .rf_din    (rf_din),
        .rf_wr     (rf_wr),
        .rf_width  (rf_width),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
`ifdef REG_XFER_SEQ_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .mem_rdata (mem_rdata)
    );

    typedef struct { logic we; logic [63:0] addr; logic [63:0] data; } mem_t;
    typedef struct { logic [3:0] sel; logic [63:0] data; logic [1:0] w; } rf_t;

    mem_t exp_mem[$];
    rf_t  exp_rf[$];
    int   exp_done = 0;
    int   tests = 0;
    int   fails = 0;
    int   mem_seen = 0;
    int   rf_seen = 0;
    int   delay_cfg = 0;
    bit   spurious_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_read(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[31:0] ^ 32'hC3A5_5A3C, ~a[31:0]};
    endfunction

    function automatic logic [63:0] wmask(input logic [1:0] w);
        return (w == 2'd3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 << w)) - 64'd1);
    endfunction

    // Reference: ascending set bits, consecutive addresses of (1<<w) bytes each.
    function automatic int push_expect(input bit ld, input logic [15:0] m, input logic [63:0] base,
                                       input logic [1:0] w, input int nmax);
        int n = 0;
        logic [63:0] a = base;
        mem_t me;
        rf_t re;
        for (int i = 0; i < 16; i++) begin
            if (m[i] && n < nmax) begin
                me.we = !ld; me.addr = a; me.data = regs[i] & wmask(w);
                exp_mem.push_back(me);
                if (ld) begin
                    re.sel = 4'(i); re.data = mem_read(a) & wmask(w); re.w = w;
                    exp_rf.push_back(re);
                end
                a = a + (64'd1 << w);
                n++;
            end
        end
        exp_done++;
        return n;
    endfunction

    // Memory responder: acks after delay_cfg request cycles, occasional stray acks when idle.
    int wait_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!mem_req) begin
            mem_ack   = spurious_en && ($urandom_range(0, 7) == 0);
            mem_rdata = {$urandom, $urandom};
            wait_cnt  = delay_cfg;
        end else if (wait_cnt == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_read(mem_addr);
        end else begin
            mem_ack = 1'b0;
            wait_cnt--;
        end
    end

    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
    logic [63:0] prev_addr = '0, prev_wdata = '0;
    mem_t        mon_m;
    rf_t         mon_r;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req && prev_req && !prev_ack) begin
                check("hold_addr", mem_addr, prev_addr);
                check("hold_wdata", mem_wdata, prev_wdata);
                check("hold_we", {63'd0, mem_we}, {63'd0, prev_we});
            end
            if (mem_req && mem_ack) begin
                mem_seen++;
                if (exp_mem.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL mem_unexpected: got request at %h, none expected", mem_addr);
                end else begin
                    mon_m = exp_mem.pop_front();
                    check("mem_we", {63'd0, mem_we}, {63'd0, mon_m.we});
                    check("mem_addr", mem_addr, mon_m.addr);
                    if (mon_m.we) check("mem_wdata", mem_wdata, mon_m.data);
                end
            end
            if (rf_wr) begin
                rf_seen++;
                if (exp_rf.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rf_unexpected: got write to R%0d, none expected", rf_wrsel);
                end else begin
                    mon_r = exp_rf.pop_front();
                    check("rf_wrsel", {60'd0, rf_wrsel}, {60'd0, mon_r.sel});
                    check("rf_din", rf_din, mon_r.data);
                    check("rf_width", {62'd0, rf_width}, {62'd0, mon_r.w});
                end
            end
            if (done) begin
                check("done_busy_low", {63'd0, busy}, 64'd0);
                if (exp_done == 0) begin
                    tests++; fails++;
                    $display("FAIL done_unexpected: got done=1, expected no completion");
                end else begin
                    exp_done--;
                end
            end
        end
        prev_req   = mem_req && !reset;
        prev_ack   = mem_ack;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
    end

    task automatic finish_checks(input int seen0, input int n);
        @(negedge clk);
        check("mem_queue_empty", 64'(exp_mem.size()), 64'd0);
        check("rf_queue_empty", 64'(exp_rf.size()), 64'd0);
        check("mem_txn_count", 64'(mem_seen - seen0), 64'(n));
        check("done_count", 64'(exp_done), 64'd0);
        check("busy_after", {63'd0, busy}, 64'd0);
    endtask

    task automatic run_op(input bit ld, input logic [15:0] m, input logic [63:0] base,
                          input logic [1:0] w, input int dly, input bit poke_busy,
                          input bit poke_fin, input int exp_lat);
        int  n, seen0, cyc;
        bit  got;
        delay_cfg = dly;
        seen0 = mem_seen;
        n = push_expect(ld, m, base, w, 16);
        @(negedge clk);
        load = ld; mask = m; base_addr = base; width = w; start = 1'b1;
        got = 1'b0;
        for (cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) begin
                check("busy_after_start", {63'd0, busy}, 64'd1);
`ifdef REG_XFER_SEQ_ABORT_EN
                check("aborted_cleared", {63'd0, aborted}, 64'd0);
`endif
            end
            if (poke_busy && cyc == 3) begin
                check("busy_at_poke", {63'd0, busy}, 64'd1);
                start = 1'b1; mask = 16'hFFFF; load = !ld; base_addr = 64'h0;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL done_timeout: got no done within 3000 cycles, expected done");
        end else if (exp_lat > 0) begin
            check("done_latency", 64'(cyc), 64'(exp_lat));
        end
        if (poke_fin) begin
            start = 1'b1; load = 1'b1; mask = 16'h00FF;
            @(negedge clk);
            start = 1'b0;
            check("fin_start_ignored", {63'd0, busy}, 64'd0);
            repeat (3) @(negedge clk);
            check("fin_start_still_idle", {63'd0, busy}, 64'd0);
        end
        finish_checks(seen0, n);
    endtask

    task automatic rand_regs();
        for (int i = 0; i < 16; i++) regs[i] = {$urandom, $urandom};
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen0, n;
        bit got;
        logic [15:0] rm;
        reset = 1'b1; start = 1'b0; load = 1'b0; mask = '0; base_addr = '0; width = '0;
        mem_ack = 1'b0; mem_rdata = '0;
`ifdef REG_XFER_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        rand_regs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_rf_wr", {63'd0, rf_wr}, 64'd0);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_sels", {56'd0, rf_rdsel, rf_wrsel}, 64'd0);
        check("rst_rf_din", rf_din, 64'd0);
        check("rst_rf_width", {62'd0, rf_width}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        reset = 1'b0;

        regs[0] = 64'hAA; regs[2] = 64'hBB;
        run_op(1'b0, 16'h0005, 64'h1000, 2'd3, 0, 1'b0, 1'b0, 0);

        mem[64'h2000] = 64'h1_DEADBEEF; mem[64'h2004] = 64'h55;
        run_op(1'b1, 16'h8001, 64'h2000, 2'd2, 1, 1'b0, 1'b1, 0);

        run_op(1'b0, 16'h0000, 64'h4000, 2'd3, 0, 1'b0, 1'b0, 2);

        rand_regs();
        run_op(1'b0, 16'h0003, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 5, 1'b1, 1'b0, 0);

        // Reset while the first request of a 4-register store is outstanding.
        delay_cfg = 5;
        @(negedge clk);
        load = 1'b0; mask = 16'h00F0; base_addr = 64'h5000; width = 2'd3; start = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_req) begin got = 1'b1; break; end
        end
        check("reset_saw_req", {63'd0, got}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_mem_req", {63'd0, mem_req}, 64'd0);
        check("reset_mid_busy", {63'd0, busy}, 64'd0);
        check("reset_mid_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        run_op(1'b0, 16'h0011, 64'h6000, 2'd1, 1, 1'b0, 1'b0, 0);

`ifdef REG_XFER_SEQ_ABORT_EN
        // Abort pulsed during the first of three loads: only that transfer happens.
        delay_cfg = 3;
        seen0 = mem_seen;
        n = push_expect(1'b1, 16'h0124, 64'h3000, 2'd3, 1);
        @(negedge clk);
        load = 1'b1; mask = 16'h0124; base_addr = 64'h3000; width = 2'd3; start = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_req) begin got = 1'b1; break; end
        end
        check("abort_saw_req", {63'd0, got}, 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (done) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("abort_done", {63'd0, got}, 64'd1);
        check("abort_flag", {63'd0, aborted}, 64'd1);
        finish_checks(seen0, n);
        check("abort_flag_held", {63'd0, aborted}, 64'd1);
        run_op(1'b1, 16'h0003, 64'h7000, 2'd3, 0, 1'b0, 1'b0, 0);
`endif

        spurious_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rand_regs();
            rm = 16'($urandom);
            if ($urandom_range(0, 5) == 0) rm = 16'h0000;
            run_op(1'($urandom), rm,
                   ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                               : {$urandom, $urandom},
                   2'($urandom), $urandom_range(0, 3), 1'b0, 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
